// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Asynchronous serial transmitter. Pops one byte at a time from
//               an upstream FIFO and shifts it out LSB first as an 8N1 frame.
//               Define UART_TX_PARITY_EN to insert an even-parity bit between
//               the data bits and the stop bits (8E1).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 217,
  parameter int DIV_WIDTH = 16,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic             txd,
  output logic             busy
);

  // Bit counter is shared by DATA (counts data bits) and STOP (counts stop bits).
  localparam int c_bit_w = $clog2(WIDTH + 1);

  localparam logic [DIV_WIDTH-1:0] c_baud_last = DIV_WIDTH'(CLK_DIV - 1);
  localparam logic [c_bit_w-1:0]   c_data_last = c_bit_w'(WIDTH - 1);
  localparam logic [c_bit_w-1:0]   c_stop_last = c_bit_w'(STOP_BITS - 1);
  localparam logic [c_bit_w-1:0]   c_bit_one   = c_bit_w'(1);
  localparam logic [DIV_WIDTH-1:0] c_baud_one  = DIV_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_STOP   = 3'd4
`ifdef UART_TX_PARITY_EN
    ,
    S_PARITY = 3'd5
`endif
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [DIV_WIDTH-1:0]   r_baud;
  logic [DIV_WIDTH-1:0]   w_baud_nxt;
  logic [c_bit_w-1:0]     r_bit_cnt;
  logic [c_bit_w-1:0]     w_bit_cnt_nxt;
  logic [WIDTH-1:0]       r_shreg;
  logic [WIDTH-1:0]       w_shreg_nxt;
  logic                   w_bit_end;
  logic                   w_txd_nxt;
  logic                   r_txd;
  logic                   r_busy;
  logic                   r_fifo_rd;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity;
  logic                   w_parity_nxt;
`endif

  assign w_bit_end = (r_baud == c_baud_last);

  // State and datapath registers; outputs are registered from the next-state
  // values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_fifo_rd <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_next_state;
      r_baud    <= w_baud_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_txd     <= w_txd_nxt;
      r_busy    <= (w_next_state != S_IDLE);
      r_fifo_rd <= (w_next_state == S_LOAD);
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end

  // Next-state, counter and shift-register logic; baud counter restarts on
  // every state change so each bit period is exactly CLK_DIV clocks.
  always_comb begin
    w_next_state  = r_state;
    w_baud_nxt    = w_bit_end ? '0 : (r_baud + c_baud_one);
    w_bit_cnt_nxt = r_bit_cnt;
    w_shreg_nxt   = r_shreg;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt  = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (en && !fifo_empty) begin
          w_next_state = S_LOAD;
        end
      end

      S_LOAD: begin
        // The FIFO head is captured here; the pop itself happens when
        // fifo_rd falls on this same edge.
        w_next_state  = S_START;
        w_shreg_nxt   = fifo_dout;
        w_baud_nxt    = '0;
        w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt  = 1'b0;
`endif
      end

      S_START: begin
        if (w_bit_end) begin
          w_next_state = S_DATA;
          w_baud_nxt   = '0;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_shreg_nxt   = r_shreg >> 1;
          w_bit_cnt_nxt = r_bit_cnt + c_bit_one;
          w_baud_nxt    = '0;
`ifdef UART_TX_PARITY_EN
          w_parity_nxt  = r_parity ^ r_shreg[0];
`endif
          if (r_bit_cnt == c_data_last) begin
            // Bit counter is reused for stop bits, so restart it here.
            w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_next_state  = S_PARITY;
`else
            w_next_state  = S_STOP;
`endif
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_next_state = S_STOP;
          w_baud_nxt   = '0;
        end
      end
`endif

      S_STOP: begin
        if (w_bit_end) begin
          if (r_bit_cnt == c_stop_last) begin
            w_next_state  = S_IDLE;
            w_bit_cnt_nxt = '0;
            w_baud_nxt    = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + c_bit_one;
          end
        end
      end

      default: begin
        w_next_state  = S_IDLE;
        w_baud_nxt    = '0;
        w_bit_cnt_nxt = '0;
      end
    endcase
  end

  // Line level for the coming clock, derived from where the FSM is heading.
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_next_state)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_txd_nxt = w_parity_nxt;
`endif
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  assign fifo_rd = r_fifo_rd;
  assign txd     = r_txd;
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed bench for uart_tx. A frame-level model predicts
//               {txd,busy,fifo_rd} for every clock; directed checks pin the
//               model with hand-computed frames. Honours UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int CD = 4;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = 1 + CD * (1 + 8 + SB + PB);

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_rd;
  logic       txd;
  logic       busy;

  // Second instance with two stop bits, fed by a one-byte source.
  logic       en2;
  logic [7:0] fifo_dout2;
  logic       fifo_empty2;
  logic       fifo_rd2;
  logic       txd2;
  logic       busy2;
  logic       armed2 = 1'b0;
  logic       popped2 = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Bench FIFO: pointer advances on the falling edge of fifo_rd.
  logic [7:0] mem [0:15];
  logic [4:0] wr_ptr = 5'd0;
  logic [4:0] rd_ptr = 5'd0;

  logic [2:0] exp_q [$];

  always #5 clk = ~clk;

  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_dout   = mem[rd_ptr[3:0]];
  assign fifo_empty2 = !(armed2 && !popped2);
  assign fifo_dout2  = 8'h00;

  always @(negedge fifo_rd) if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 5'd1;
  always @(negedge fifo_rd2) if (armed2) popped2 <= 1'b1;

  uart_tx #(.WIDTH(8), .CLK_DIV(CD), .DIV_WIDTH(16), .STOP_BITS(SB)) dut (
    .clk(clk), .reset(reset), .en(en), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .txd(txd), .busy(busy)
  );

  uart_tx #(.WIDTH(8), .CLK_DIV(CD), .DIV_WIDTH(16), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .fifo_dout(fifo_dout2),
    .fifo_empty(fifo_empty2), .fifo_rd(fifo_rd2), .txd(txd2), .busy(busy2)
  );

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  // Expected per-clock {txd,busy,fifo_rd} for one whole frame of byte d.
  task automatic model_frame(input logic [7:0] d);
    exp_q.push_back(3'b111);
    repeat (CD) exp_q.push_back(3'b010);
    for (int i = 0; i < 8; i++) repeat (CD) exp_q.push_back({d[i], 2'b10});
`ifdef UART_TX_PARITY_EN
    repeat (CD) exp_q.push_back({^d, 2'b10});
`endif
    repeat (CD * SB) exp_q.push_back(3'b110);
  endtask

  // Per-clock comparison against the model; new frames start only from idle.
  task automatic checker_loop();
    logic [2:0] e;
    logic       was_idle;
    forever begin
      @(negedge clk);
      was_idle = (exp_q.size() == 0);
      e = was_idle ? 3'b100 : exp_q.pop_front();
      n_tests++;
      if ({txd, busy, fifo_rd} !== e) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t {txd,busy,rd} actual=%b required=%b",
                 $time, {txd, busy, fifo_rd}, e);
      end
      if (reset) exp_q.delete();
      else if (was_idle && en && !fifo_empty) model_frame(fifo_dout);
    end
  endtask

  // Wait for the next pop pulse and record the line until busy falls.
  task automatic capture(output logic [7:0] b, output logic [8:0] lv,
                         output int len, output int waits, output int rdc,
                         output logic par, output logic hold_ok,
                         output logic stop_ok);
    logic s [0:99];
    b = 8'h00; lv = '0; len = 0; waits = 0; rdc = 0;
    par = 1'b0; hold_ok = 1'b1; stop_ok = 1'b0;
    @(negedge clk);
    while (!fifo_rd && waits < 200) begin waits++; @(negedge clk); end
    if (!fifo_rd) begin
      n_tests++; n_fail++;
      $display("FAIL capture_timeout actual=no fifo_rd required=fifo_rd within 200 clocks");
      return;
    end
    while (busy && len < 100) begin
      s[len] = txd;
      if (fifo_rd) rdc++;
      len++;
      @(negedge clk);
    end
    if (len < FRAME) return;
    for (int k = 0; k < 9; k++) begin
      lv[k] = s[1 + CD * k];
      for (int j = 1; j < CD; j++) if (s[1 + CD * k + j] !== lv[k]) hold_ok = 1'b0;
    end
    b = lv[8:1];
    par = s[1 + CD * 9];
    stop_ok = (s[len - 1] == 1'b1) && (s[len - CD] == 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [8:0] lv;
    int len, waits, rdc, cnt, lows, highs;
    logic par, hold_ok, stop_ok;

    reset = 1'b1; en = 1'b0; en2 = 1'b0;
    @(posedge clk); #1;
    fork checker_loop(); join_none
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; en = 1'b1;

    // Empty FIFO with enable high: line stays idle, no pops.
    cnt = 0;
    repeat (100) begin @(negedge clk); if (fifo_rd) cnt++; end
    chk("idle_rd_pulses", cnt, 0);
    chk("idle_txd", int'(txd), 1);
    chk("idle_busy", int'(busy), 0);

    // Single 0x55 frame.
    @(posedge clk); #1 push(8'h55);
    capture(b, lv, len, waits, rdc, par, hold_ok, stop_ok);
    chk("f55_data", int'(b), 8'h55);
    chk("f55_levels", int'(lv), 9'b010101010);
    chk("f55_hold", int'(hold_ok), 1);
    chk("f55_stop", int'(stop_ok), 1);
    chk("f55_rd_pulses", rdc, 1);
    chk("f55_busy_len", len, FRAME);
    chk("f55_busy_literal", len, 41 + 4 * PB);

    // en dropped mid-frame: current frame still completes.
    @(posedge clk); #1 push(8'hC5);
    fork
      capture(b, lv, len, waits, rdc, par, hold_ok, stop_ok);
      begin repeat (12) @(posedge clk); #1 en = 1'b0; end
    join
    chk("fC5_data", int'(b), 8'hC5);
    chk("fC5_len", len, FRAME);

    // en low in IDLE holds off a queued byte.
    @(posedge clk); #1 push(8'h11);
    cnt = 0;
    repeat (30) begin @(negedge clk); if (fifo_rd || busy) cnt++; end
    chk("en_low_hold", cnt, 0);
    @(posedge clk); #1 en = 1'b1;
    capture(b, lv, len, waits, rdc, par, hold_ok, stop_ok);
    chk("f11_data", int'(b), 8'h11);

    // Three frames back-to-back.
    @(posedge clk); #1 push(8'hA3); push(8'h0F); push(8'hFF);
    capture(b, lv, len, waits, rdc, par, hold_ok, stop_ok);
    chk("fA3_data", int'(b), 8'hA3);
    capture(b, lv, len, waits, rdc, par, hold_ok, stop_ok);
    chk("f0F_data", int'(b), 8'h0F);
    chk("f0F_gap", waits, 0);
    capture(b, lv, len, waits, rdc, par, hold_ok, stop_ok);
    chk("fFF_data", int'(b), 8'hFF);
    chk("fFF_gap", waits, 0);
    chk("fFF_stop", int'(stop_ok), 1);
    cnt = 0;
    repeat (20) begin @(negedge clk); if (!busy && txd) cnt++; end
    chk("after_b2b_idle", cnt, 20);

    // Parity frames.
    @(posedge clk); #1 push(8'h07); push(8'h03);
    capture(b, lv, len, waits, rdc, par, hold_ok, stop_ok);
    chk("f07_data", int'(b), 8'h07);
    chk("f07_len", len, FRAME);
`ifdef UART_TX_PARITY_EN
    chk("f07_parity", int'(par), 1);
    chk("f07_len_literal", len, 45);
`endif
    capture(b, lv, len, waits, rdc, par, hold_ok, stop_ok);
    chk("f03_data", int'(b), 8'h03);
`ifdef UART_TX_PARITY_EN
    chk("f03_parity", int'(par), 0);
`endif

    // Reset during data bit 3; next byte goes out intact, lost one is not resent.
    @(posedge clk); #1 push(8'h3C); push(8'h5A);
    waits = 0;
    @(negedge clk);
    while (!fifo_rd && waits < 200) begin waits++; @(negedge clk); end
    chk("rst_frame_started", int'(fifo_rd), 1);
    repeat (18) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_txd", int'(txd), 1);
    chk("rst_busy", int'(busy), 0);
    capture(b, lv, len, waits, rdc, par, hold_ok, stop_ok);
    chk("f5A_after_rst", int'(b), 8'h5A);
    chk("f5A_len", len, FRAME);
    cnt = 0;
    repeat (60) begin @(negedge clk); if (fifo_rd) cnt++; end
    chk("no_resend", cnt, 0);

    // Two stop bits, byte 0x00.
    @(posedge clk); #1 armed2 = 1'b1; en2 = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!fifo_rd2 && waits < 50) begin waits++; @(negedge clk); end
    chk("sb2_rd", int'(fifo_rd2), 1);
    lows = 0; highs = 0;
    @(negedge clk);
    while (txd2 == 1'b0 && lows < 100) begin lows++; @(negedge clk); end
    while (busy2 && txd2 && highs < 100) begin highs++; @(negedge clk); end
    chk("sb2_low_len", lows, 36 + 4 * PB);
    chk("sb2_high_len", highs, 8);
    chk("sb2_idle_busy", int'(busy2), 0);
    chk("sb2_idle_txd", int'(txd2), 1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drains the transmit FIFO of the computer's UART path and shifts each byte out on a TX line as an asynchronous 8N1 (optionally 8E1) frame. Sits directly downstream of the transmit FIFO: it watches `empty`, captures `dout`, and issues one `rd` pulse per byte. The FIFO's read pointer advances on the falling edge of `rd`, so the pulse format defined here is mandatory.

## Interface
- `WIDTH`, 8: data bits per frame; must match the FIFO `WIDTH`.
- `CLK_DIV`, 217: clocks per bit period, minimum 2.
- `DIV_WIDTH`, 16: width of the baud counter; must satisfy 2**DIV_WIDTH > CLK_DIV.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  transmit enable; sampled only in IDLE.
- `fifo_dout`  in  WIDTH  FIFO head data.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd`  out  1  registered one-clock read/pop pulse to the FIFO.
- `txd`  out  1  serial output; idle level is high.
- `busy`  out  1  high from LOAD through the end of STOP.

## Operation
- States: IDLE, LOAD, START, DATA, PARITY (only with the macro), STOP.
- IDLE: `txd`=1, `busy`=0. If `en` & ~`fifo_empty`, go to LOAD on the next edge. Otherwise stay in IDLE.
- LOAD (exactly 1 clock): `fifo_rd`=1, `busy`=1, `txd`=1. On the exit edge:
  - `fifo_dout` is latched into the shift register;
  - the baud counter and bit counter are cleared;
  - the parity accumulator is cleared;
  - go to START.
- START: `txd`=0 for CLK_DIV clocks.
- DATA: `txd` = shreg[0] (LSB first). Each bit is held for CLK_DIV clocks.
  - At each bit end: shift right, increment the bit counter, XOR the sent bit into parity.
  - After bit WIDTH-1, go to PARITY if the macro is set, else STOP.
- PARITY: `txd` = even-parity bit for CLK_DIV clocks.
- STOP: `txd`=1 for STOP_BITS*CLK_DIV clocks, then IDLE.
- Baud counter: counts 0..CLK_DIV-1 and wraps to 0.
  - The "bit end" strobe is count==CLK_DIV-1.
  - The counter is cleared on every state change.
- Bit counter width is clog2(WIDTH+1). No arithmetic overflow is possible.
- `fifo_rd` is never high outside LOAD and never high for more than one clock. Exactly one pulse per frame.
- `en` deasserted mid-frame has no effect; the current frame completes.
- `fifo_empty` and `fifo_dout` are ignored outside IDLE and LOAD.

## Timing
- Reset values: `txd`=1, `fifo_rd`=0, `busy`=0, state=IDLE, all counters 0.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Start latency: from the edge where IDLE sees non-empty, `fifo_rd` is high in the next clock. The `txd` falling edge comes 1 clock after that.
- Frame length, LOAD through the last STOP clock: 1 + CLK_DIV*(1+WIDTH+STOP_BITS[+1 with parity]) clocks.
- Back-to-back frames: after STOP, IDLE lasts 1 clock, then LOAD. The gap between frames is therefore 2 extra high clocks beyond the stop bits.
  - The FIFO pointer advances when `fifo_rd` falls (start of START).
  - `fifo_empty`/`fifo_dout` are settled well before the next IDLE check.
- Empty boundary: when the last byte is popped, IDLE sees `fifo_empty`=1 and holds. `busy` drops in the IDLE clock.
- Reset mid-frame: on the next edge `txd`=1, `busy`=0, state=IDLE. The byte in flight is lost and not re-read, because it was already popped. A reset asserted in the LOAD clock still leaves the FIFO pop to occur on `fifo_rd` falling.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in.
  - One even-parity bit (XOR of all WIDTH data bits) is sent between the data bits and the stop bits.
  - Frame length grows by CLK_DIV.
- Not defined: PARITY state, parity accumulator and related logic are absent. DATA goes straight to STOP (8N1).

## Test plan
- Reset, then hold with FIFO empty and `en`=1 for 100 clocks -> `txd`=1, `busy`=0, `fifo_rd` never high.
- CLK_DIV=4, push 0x55, `en`=1 -> exactly one `fifo_rd` pulse 1 clock wide; `txd` shows 0,1,0,1,0,1,0,1,0,1 with each level held 4 clocks; `busy` is high for 41 clocks.
- CLK_DIV=4, push 0xA3, 0x0F, 0xFF back-to-back -> three frames decoded LSB-first as 0xA3, 0x0F, 0xFF; 2 extra high clocks between stop bits and the next start bit; `busy` low once after the third frame.
- With `UART_TX_PARITY_EN`, CLK_DIV=4, send 0x07 then 0x03 -> parity bit 1 for 0x07, parity bit 0 for 0x03; frame length 45 clocks.
- Assert `reset` 1 clock in the middle of data bit 3 -> the next clock gives `txd`=1, `busy`=0; the following FIFO byte is then sent complete and correct; the interrupted byte is not resent.
- STOP_BITS=2, CLK_DIV=4, send 0x00 -> `txd` low for 36 clocks, then high for 8 clocks before IDLE.
